// File: rtl/conv_3x3_sched_ctrl.sv
// Pass sequencer for a 3x3 conv core: per (output ch, input ch) pass it accepts
// KERNEL_SIZE weights, then one pixel plane, and forwards both as registered strobes.
module conv_3x3_sched_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 32,
  parameter int IMAGE_HEIGHT    = 32,
  parameter int CHANNEL_NUM_IN  = 128,
  parameter int CHANNEL_NUM_OUT = 128,
  parameter int KERNEL_SIZE     = 9,
  localparam int CI_W = (CHANNEL_NUM_IN  > 1) ? $clog2(CHANNEL_NUM_IN)  : 1,
  localparam int CO_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  src_pxl_valid,
  input  logic [DATA_WIDTH-1:0] src_pxl_data,
  output logic                  src_pxl_ready,
  input  logic                  src_wgt_valid,
  input  logic [DATA_WIDTH-1:0] src_wgt_data,
  output logic                  src_wgt_ready,
  output logic                  conv_valid_in,
  output logic [DATA_WIDTH-1:0] conv_pxl_in,
  output logic                  conv_valid_w,
  output logic [DATA_WIDTH-1:0] conv_weight_in,
  output logic [CI_W-1:0]       ch_in_idx,
  output logic [CO_W-1:0]       ch_out_idx,
  output logic                  last_in_ch,
  output logic                  busy,
  output logic                  done
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int WC_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int PC_W = (IMAGE_SIZE  > 1) ? $clog2(IMAGE_SIZE)  : 1;

  localparam logic [WC_W-1:0] WGT_LAST = WC_W'(KERNEL_SIZE - 1);
  localparam logic [PC_W-1:0] PXL_LAST = PC_W'(IMAGE_SIZE - 1);
  localparam logic [CI_W-1:0] CI_LAST  = CI_W'(CHANNEL_NUM_IN - 1);
  localparam logic [CO_W-1:0] CO_LAST  = CO_W'(CHANNEL_NUM_OUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, NEXT, FIN} state_t;

  state_t          state;
  logic [WC_W-1:0] wgt_cnt;
  logic [PC_W-1:0] pxl_cnt;
  logic            wgt_xfer;
  logic            pxl_xfer;

  // Readies decode the state register only, so valid never reaches ready combinationally.
  assign src_wgt_ready = (state == LOAD_W);
  assign src_pxl_ready = (state == STREAM);
  assign wgt_xfer      = src_wgt_valid & src_wgt_ready;
  assign pxl_xfer      = src_pxl_valid & src_pxl_ready;
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign last_in_ch    = (ch_in_idx == CI_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wgt_cnt    <= '0;
      pxl_cnt    <= '0;
      ch_in_idx  <= '0;
      ch_out_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= LOAD_W;
        end
        LOAD_W: begin
          if (wgt_xfer) begin
            if (wgt_cnt == WGT_LAST) begin
              wgt_cnt <= '0;
              state   <= STREAM;
            end else begin
              wgt_cnt <= wgt_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (pxl_xfer) begin
            if (pxl_cnt == PXL_LAST) begin
              pxl_cnt <= '0;
              state   <= NEXT;
            end else begin
              pxl_cnt <= pxl_cnt + 1'b1;
            end
          end
        end
        NEXT: begin
          wgt_cnt <= '0;
          pxl_cnt <= '0;
          if (ch_in_idx != CI_LAST) begin
            ch_in_idx <= ch_in_idx + 1'b1;
            state     <= LOAD_W;
          end else begin
            ch_in_idx <= '0;
            if (ch_out_idx != CO_LAST) begin
              ch_out_idx <= ch_out_idx + 1'b1;
              state      <= LOAD_W;
            end else begin
              state <= FIN;
            end
          end
        end
        FIN: begin
          state      <= IDLE;
          ch_in_idx  <= '0;
          ch_out_idx <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conv_valid_w   <= 1'b0;
      conv_valid_in  <= 1'b0;
      conv_weight_in <= '0;
      conv_pxl_in    <= '0;
    end else begin
      conv_valid_w  <= wgt_xfer;
      conv_valid_in <= pxl_xfer;
      if (wgt_xfer) conv_weight_in <= src_wgt_data;
      if (pxl_xfer) conv_pxl_in    <= src_pxl_data;
    end
  end

endmodule

// File: tb/tb_conv_3x3_sched_ctrl.sv
// Directed bench for conv_3x3_sched_ctrl with a 4x4 plane, 2 input and 2 output channels.
module tb_conv_3x3_sched_ctrl;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          src_pxl_valid = 1'b0;
  logic [DW-1:0] src_pxl_data = '0;
  logic          src_pxl_ready;
  logic          src_wgt_valid = 1'b0;
  logic [DW-1:0] src_wgt_data = '0;
  logic          src_wgt_ready;
  logic          conv_valid_in;
  logic [DW-1:0] conv_pxl_in;
  logic          conv_valid_w;
  logic [DW-1:0] conv_weight_in;
  logic          ch_in_idx;
  logic          ch_out_idx;
  logic          last_in_ch;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_3x3_sched_ctrl #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
    .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .KERNEL_SIZE(9)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_pxl_valid(src_pxl_valid), .src_pxl_data(src_pxl_data), .src_pxl_ready(src_pxl_ready),
    .src_wgt_valid(src_wgt_valid), .src_wgt_data(src_wgt_data), .src_wgt_ready(src_wgt_ready),
    .conv_valid_in(conv_valid_in), .conv_pxl_in(conv_pxl_in),
    .conv_valid_w(conv_valid_w), .conv_weight_in(conv_weight_in),
    .ch_in_idx(ch_in_idx), .ch_out_idx(ch_out_idx), .last_in_ch(last_in_ch),
    .busy(busy), .done(done)
  );

  // Phases of the bench model: 0 idle, 1 load weights, 2 stream pixels, 3 gap cycle, 4 finish.
  task automatic run_layer(input bit gaps, input int abort_pass, input int abort_pxl, input string tag);
    int phase = 1, pass = 0, wc = 0, pc = 0, nw = 0, np = 0, nd = 0, cyc = 0;
    bit pw = 0, pp = 0, wx, px, aborted = 0;
    logic [DW-1:0] pwd = '0, ppd = '0, wd, pd;
    @(negedge clk);
    start = 1'b1; src_wgt_valid = 1'b0; src_pxl_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    forever begin
      n_checks++;
      if (conv_valid_w !== pw) begin
        n_fail++; $display("FAIL %s wgt_strobe cyc=%0d: got %b expected %b", tag, cyc, conv_valid_w, pw);
      end
      if (pw) begin
        n_checks++;
        if (conv_weight_in !== pwd) begin
          n_fail++; $display("FAIL %s wgt_data cyc=%0d: got %h expected %h", tag, cyc, conv_weight_in, pwd);
        end
      end
      n_checks++;
      if (conv_valid_in !== pp) begin
        n_fail++; $display("FAIL %s pxl_strobe cyc=%0d: got %b expected %b", tag, cyc, conv_valid_in, pp);
      end
      if (pp) begin
        n_checks++;
        if (conv_pxl_in !== ppd) begin
          n_fail++; $display("FAIL %s pxl_data cyc=%0d: got %h expected %h", tag, cyc, conv_pxl_in, ppd);
        end
      end
      n_checks++;
      if (src_wgt_ready !== (phase == 1) || src_pxl_ready !== (phase == 2)) begin
        n_fail++; $display("FAIL %s readies cyc=%0d phase=%0d: got wgt=%b pxl=%b", tag, cyc, phase, src_wgt_ready, src_pxl_ready);
      end
      n_checks++;
      if (busy !== (phase != 0) || done !== (phase == 4)) begin
        n_fail++; $display("FAIL %s busy_done cyc=%0d phase=%0d: got busy=%b done=%b", tag, cyc, phase, busy, done);
      end
      if (phase == 1 || phase == 2) begin
        n_checks++;
        if (ch_out_idx !== 1'(pass / 2) || ch_in_idx !== 1'(pass % 2) || last_in_ch !== (pass % 2 == 1)) begin
          n_fail++; $display("FAIL %s indices pass=%0d: got co=%b ci=%b last=%b", tag, pass, ch_out_idx, ch_in_idx, last_in_ch);
        end
      end
      if (done === 1'b1) nd++;
      if (phase == 0) break;
      if (cyc >= 3000) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: got phase %0d expected 0 within 3000 cycles", tag, phase);
        break;
      end
      if (pass == abort_pass && phase == 2 && pc == abort_pxl) begin
        aborted = 1;
        break;
      end
      wd = 32'hA000_0000 + 32'(pass * 16 + wc);
      pd = 32'hB000_0000 + 32'(pass * 256 + pc);
      src_wgt_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      src_pxl_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      src_wgt_data  = wd;
      src_pxl_data  = pd;
      wx = src_wgt_valid && src_wgt_ready;
      px = src_pxl_valid && src_pxl_ready;
      pw = wx; pwd = wd; pp = px; ppd = pd;
      if (wx) nw++;
      if (px) np++;
      case (phase)
        1: if (wx) begin wc++; if (wc == 9) begin wc = 0; phase = 2; end end
        2: if (px) begin pc++; if (pc == 16) begin pc = 0; phase = 3; end end
        3: begin pass++; phase = (pass == 4) ? 4 : 1; end
        4: phase = 0;
        default: phase = 0;
      endcase
      @(negedge clk);
      cyc++;
    end
    if (aborted) begin
      src_pxl_valid = 1'b1;
      src_pxl_data  = 32'hB000_0000 + 32'(pass * 256 + pc);
      reset = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || src_wgt_ready !== 1'b0 || src_pxl_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s abort_state: got busy=%b done=%b rw=%b rp=%b expected all 0", tag, busy, done, src_wgt_ready, src_pxl_ready);
      end
      n_checks++;
      if (conv_valid_in !== 1'b0 || conv_valid_w !== 1'b0 || ch_in_idx !== 1'b0 || ch_out_idx !== 1'b0) begin
        n_fail++; $display("FAIL %s abort_outputs: got vi=%b vw=%b ci=%b co=%b expected all 0", tag, conv_valid_in, conv_valid_w, ch_in_idx, ch_out_idx);
      end
      @(negedge clk);
      reset = 1'b0; src_pxl_valid = 1'b0; src_wgt_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || nd != 0) begin
        n_fail++; $display("FAIL %s abort_idle: got busy=%b done=%b pulses=%0d expected 0 0 0", tag, busy, done, nd);
      end
    end else begin
      src_wgt_valid = 1'b0; src_pxl_valid = 1'b0;
      n_checks++;
      if (nw != 36 || np != 64) begin
        n_fail++; $display("FAIL %s xfer_count: got w=%0d p=%0d expected 36 64", tag, nw, np);
      end
      n_checks++;
      if (nd != 1) begin
        n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", tag, nd);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; src_wgt_valid = 1'b1; src_pxl_valid = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (src_wgt_ready !== 1'b0 || src_pxl_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got rw=%b rp=%b busy=%b done=%b expected 0", src_wgt_ready, src_pxl_ready, busy, done);
    end
    n_checks++;
    if (conv_valid_in !== 1'b0 || conv_valid_w !== 1'b0 || conv_pxl_in !== '0 || conv_weight_in !== '0) begin
      n_fail++; $display("FAIL reset_conv: got vi=%b vw=%b p=%h w=%h expected 0", conv_valid_in, conv_valid_w, conv_pxl_in, conv_weight_in);
    end
    n_checks++;
    if (ch_in_idx !== 1'b0 || ch_out_idx !== 1'b0 || last_in_ch !== 1'b0) begin
      n_fail++; $display("FAIL reset_idx: got ci=%b co=%b last=%b expected 0", ch_in_idx, ch_out_idx, last_in_ch);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || src_wgt_ready !== 1'b0 || src_pxl_ready !== 1'b0 || conv_valid_w !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got busy=%b rw=%b rp=%b vw=%b expected 0", busy, src_wgt_ready, src_pxl_ready, conv_valid_w);
    end
    src_wgt_valid = 1'b0; src_pxl_valid = 1'b0;
  endtask

  task automatic test_full_layer();
    run_layer(1'b0, -1, -1, "full");
  endtask

  task automatic test_random_gaps();
    run_layer(1'b1, -1, -1, "gaps");
  endtask

  task automatic test_ready_isolation();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; src_wgt_valid = 1'b0; src_pxl_valid = 1'b1; src_pxl_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (src_wgt_ready !== 1'b1 || src_pxl_ready !== 1'b0 || conv_valid_in !== 1'b0 || conv_valid_w !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL isolation cyc=%0d: got rw=%b rp=%b vi=%b vw=%b busy=%b expected 1 0 0 0 1",
                           i, src_wgt_ready, src_pxl_ready, conv_valid_in, conv_valid_w, busy);
      end
    end
    n_checks++;
    if (conv_pxl_in === 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL isolation_data: got %h expected unaccepted value absent", conv_pxl_in);
    end
    src_pxl_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_pass();
    run_layer(1'b0, 2, 4, "abort");
    run_layer(1'b0, -1, -1, "after_abort");
  endtask

  task automatic test_back_to_back();
    run_layer(1'b1, -1, -1, "b2b_a");
    run_layer(1'b0, -1, -1, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_random_gaps();
    test_ready_isolation();
    test_reset_mid_pass();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
